// File: rtl/step_sequence_controller.sv
// Step pattern sequencer: walks a tone-mask pattern one step per beat,
// counting passes against a programmed loop count.
module step_sequence_controller #(
   parameter int NUM_STEPS = 16,
   parameter int STEP_W    = 4,
   parameter int TONE_W    = 12,
   parameter int LOOP_W    = 7
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [LOOP_W-1:0] loops,
   input  logic              step_tick,
   input  logic              pat_wr_en,
   input  logic [STEP_W-1:0] pat_wr_addr,
   input  logic [TONE_W-1:0] pat_wr_data,
   output logic [TONE_W-1:0] select,
   output logic [STEP_W-1:0] step_idx,
   output logic              playing,
   output logic              note_on,
   output logic [LOOP_W-1:0] loop_count,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [TONE_W-1:0] pat_q [NUM_STEPS];
   logic [TONE_W-1:0] select_q, select_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [LOOP_W-1:0] lc_q, lc_d;
   logic [LOOP_W-1:0] loops_q, loops_d;
   logic              play_q, play_d;
   logic              done_q, done_d;

   logic [STEP_W-1:0] nxt_idx;
   logic [LOOP_W-1:0] lc_inc;
   logic [TONE_W-1:0] fwd0, fwdn;
   logic              last_step;

   // Entries being loaded see a same-cycle write to that address.
   always_comb begin
      nxt_idx   = step_q + STEP_W'(1);
      lc_inc    = lc_q + LOOP_W'(1);
      last_step = (step_q == STEP_W'(NUM_STEPS - 1));
      fwd0 = (pat_wr_en && pat_wr_addr == '0) ? pat_wr_data : pat_q[0];
      fwdn = (pat_wr_en && pat_wr_addr == nxt_idx) ? pat_wr_data
                                                   : pat_q[nxt_idx];
   end

   always_comb begin
      state_d  = state_q;
      select_d = select_q;
      step_d   = step_q;
      lc_d     = lc_q;
      loops_d  = loops_q;
      play_d   = play_q;
      done_d   = 1'b0;
      if (stop || state_q == DONE) begin
         state_d  = IDLE;
         select_d = '0;
         step_d   = '0;
         play_d   = 1'b0;
      end else if (start) begin
         state_d  = RUN;
         loops_d  = loops;
         step_d   = '0;
         lc_d     = '0;
         select_d = fwd0;
         play_d   = 1'b1;
      end else if (state_q == RUN && step_tick) begin
         if (!last_step) begin
            step_d   = nxt_idx;
            select_d = fwdn;
         end else begin
            lc_d   = lc_inc;
            step_d = '0;
            if (loops_q != '0 && lc_inc == loops_q) begin
               state_d  = DONE;
               select_d = '0;
               play_d   = 1'b0;
               done_d   = 1'b1;
            end else begin
               select_d = fwd0;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= IDLE;
         select_q <= '0;
         step_q   <= '0;
         lc_q     <= '0;
         loops_q  <= '0;
         play_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         step_q   <= step_d;
         lc_q     <= lc_d;
         loops_q  <= loops_d;
         play_q   <= play_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < NUM_STEPS; i++) pat_q[i] <= '0;
      end else if (pat_wr_en) begin
         pat_q[pat_wr_addr] <= pat_wr_data;
      end
   end

   assign select     = select_q;
   assign step_idx   = step_q;
   assign playing    = play_q;
   assign note_on    = play_q && (select_q != '0);
   assign loop_count = lc_q;
   assign done       = done_q;

endmodule

// File: doc/step_sequence_controller.md
# step_sequence_controller

Pattern sequencer that drives the tone-select and playback-enable inputs of the audio datapath. It holds a NUM_STEPS-entry pattern of tone masks and advances one step per BPM step pulse. It counts completed passes against a requested loop count and reports completion. It replaces direct switch-driven tone selection and is the single owner of `Select`/`Play` for the tone generators, codec path and external DAC path.

## Interface
Parameters:
- NUM_STEPS, 16, pattern length; power of two, ≥2
- STEP_W, 4, log2(NUM_STEPS)
- TONE_W, 12, tone-mask width (one bit per tone)
- LOOP_W, 7, loop-count width

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high; the only reset
- start  in  1  one-cycle pulse; begin or restart playback
- stop  in  1  one-cycle pulse; abort playback
- loops  in  LOOP_W  passes to play; 0 = play until stop; sampled only on accepted start
- step_tick  in  1  one-cycle pulse per beat from the BPM counter
- pat_wr_en  in  1  pattern write strobe
- pat_wr_addr  in  STEP_W  pattern entry to write
- pat_wr_data  in  TONE_W  tone mask; 0 = rest
- select  out  TONE_W  tone mask for the current step; 0 when not playing
- step_idx  out  STEP_W  current step index
- playing  out  1  playback active
- note_on  out  1  playing && select != 0
- loop_count  out  LOOP_W  completed passes since the last start
- done  out  1  one-cycle pulse when the programmed loops finish

## Operation
- Pattern storage: NUM_STEPS × TONE_W register array. Written whenever pat_wr_en=1, in any state.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 (and stop=0) → RUN.
  - Latch loops into loops_q; step_idx←0; loop_count←0; select←pattern[0]; playing←1.
  - step_tick ignored.
- RUN, step_tick=1:
  - step_idx<NUM_STEPS-1: step_idx+1; select←pattern[step_idx+1].
  - step_idx=NUM_STEPS-1: loop_count+1 (wraps at 2^LOOP_W).
    - If loops_q≠0 and loop_count+1=loops_q → DONE.
    - Else step_idx←0; select←pattern[0].
- RUN, start=1: restart exactly as from IDLE; re-latch loops. Takes precedence over a simultaneous step_tick.
- RUN, stop=1: → IDLE; playing←0; select←0; step_idx←0; loop_count holds; no done pulse.
- DONE: lasts one cycle with done=1, playing=0, select=0, step_idx=0. Then → IDLE unconditionally; start in DONE is ignored.
- Priority, any state: reset > stop > start > step_tick.
- Write forwarding: a pattern write to the entry being loaded into select in the same cycle supplies the new data.
- A write to the step currently held in select does not change select until that step is re-entered.
- loop_count holds its final value in IDLE until the next accepted start.

## Timing
- All outputs registered. Reset values: select=0, step_idx=0, playing=0, note_on=0, loop_count=0, done=0, state=IDLE. Pattern array cleared to 0.
- start accepted on edge N → playing=1, select=pattern[0] at edge N+1.
- step_tick on edge N → new step_idx/select at edge N+1.
- Final tick of the last pass on edge N → done=1, playing=0 at N+1; done=0 at N+2.
- stop on edge N → playing=0, select=0 at N+1.
- note_on is derived from registered state: same-cycle as select, no extra latency.
- step_tick is assumed to be a one-cycle pulse. Back-to-back ticks advance one step per cycle.

## Test plan
- Reset, then write pattern[i]=1<<(i%12) for i=0..15. Pulse start with loops=2, then apply 32 step_ticks. Expect: select follows 0x001,0x002,…; loop_count 1 after tick 16; done pulse one cycle after tick 32; playing=0, loop_count=2.
- loops=0, 40 ticks, then stop. Expect step_idx wraps 15→0 twice; playing stays 1 until stop; playing=0 and select=0 one cycle after stop; no done pulse.
- Pattern[3]=0. Expect note_on=0 while step_idx=3 with playing=1.
- Write pattern[5]=0xABC in the same cycle as the tick moving 4→5. Expect select=0xABC. Write pattern[5]=0x111 while on step 5: select stays 0xABC until the next visit.
- Mid-run at step 7 with loop_count=1, pulse start together with step_tick (loops=1). Expect step_idx=0, loop_count=0, select=pattern[0]. Pulse start and stop together in IDLE: playing stays 0.
- Assert reset during RUN at step 9. Expect all outputs 0 next cycle and pattern cleared (start then gives select=0).
